// File: rtl/prog_ctr_pkg.sv
// Shared types and defaults for the program counter stage.
package prog_ctr_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;

   localparam int unsigned PC_W           = 12;
   localparam int unsigned START_ADDR_DEF = 0;
   localparam int unsigned CNT_W_DEF      = 16;

endpackage

// File: rtl/prog_ctr_if.sv
// Control/status bundle between the branch-target LUT side and the PC stage.
interface prog_ctr_if import prog_ctr_pkg::*; #(
   parameter int unsigned D     = PC_W,
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic             start;
   logic             stall;
   logic             halt;
   logic             branch_en;
   logic             rel_en;
   logic [D-1:0]     target;
   logic             call_en;
   logic             ret_en;
   logic [D-1:0]     prog_ctr;
   logic             running;
   logic             done;
   logic [CNT_W-1:0] instr_cnt;
   logic             ras_err;

   modport master (
      output start, stall, halt, branch_en, rel_en, target, call_en, ret_en,
      input  prog_ctr, running, done, instr_cnt, ras_err
   );

   modport slave (
      input  start, stall, halt, branch_en, rel_en, target, call_en, ret_en,
      output prog_ctr, running, done, instr_cnt, ras_err
   );
endinterface

// File: rtl/prog_ctr_ras_stack.sv
// Return-address LIFO; a push when full silently overwrites the oldest entry.
module ras_stack import prog_ctr_pkg::*; #(
   parameter int unsigned W     = PC_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_idx;
   logic [CW-1:0] count;

   // Circular storage: wr_ptr is the next free slot, so the top lives one below it.
   assign rd_idx = (wr_ptr == '0) ? AW'(DEPTH - 1) : wr_ptr - AW'(1);
   assign dout   = mem[rd_idx];
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (!full) count <= count + CW'(1);
      end else if (pop && !empty) begin
         wr_ptr <= rd_idx;
         count  <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/prog_ctr.sv
// Program counter stage with idle/run/done control and retired-instruction count.
// Optional return-address stack enabled by defining PROG_CTR_RAS_EN.
module prog_ctr import prog_ctr_pkg::*; #(
   parameter int unsigned D          = PC_W,
   parameter int unsigned START_ADDR = START_ADDR_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned RAS_DEPTH  = 4
) (
   input  logic      clk,
   input  logic      reset,
   prog_ctr_if.slave bus
);
   pc_state_t        state_q, state_d;
   logic [D-1:0]     pc_q, pc_d;
   logic [D-1:0]     pc_inc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             running_q, done_q;
   logic             push, pop;

`ifdef PROG_CTR_RAS_EN
   logic [D-1:0]     ras_top;
   logic             ras_full, ras_empty;
   logic             err_q;
`endif

   assign pc_inc  = pc_q + D'(1);
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            pc_d = D'(START_ADDR);
            if (bus.start) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (bus.start) begin
               pc_d  = D'(START_ADDR);
               cnt_d = '0;
            end else if (bus.halt) begin
               state_d = DONE;
               cnt_d   = cnt_inc;
            end else if (!bus.stall) begin
               cnt_d = cnt_inc;
               if (bus.call_en) begin
                  pc_d = bus.target;
                  push = 1'b1;
               end
`ifdef PROG_CTR_RAS_EN
               else if (bus.ret_en) begin
                  pop  = 1'b1;
                  pc_d = ras_empty ? pc_inc : ras_top;
               end
`endif
               // Unsigned D-bit add equals the signed offset result modulo 2^D.
               else if (bus.branch_en) pc_d = bus.rel_en ? pc_q + bus.target : bus.target;
               else                    pc_d = pc_inc;
            end
         end
         DONE: begin
            if (bus.start) begin
               state_d = RUN;
               pc_d    = D'(START_ADDR);
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = D'(START_ADDR);
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= D'(START_ADDR);
         cnt_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         running_q <= (state_d == RUN);
         done_q    <= (state_d == DONE);
      end
   end

   assign bus.prog_ctr  = pc_q;
   assign bus.running   = running_q;
   assign bus.done      = done_q;
   assign bus.instr_cnt = cnt_q;

`ifdef PROG_CTR_RAS_EN
   ras_stack #(.W(D), .DEPTH(RAS_DEPTH)) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (ras_top),
      .full  (ras_full),
      .empty (ras_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                             err_q <= 1'b0;
      else if ((push && ras_full) || (pop && ras_empty))     err_q <= 1'b1;
   end

   assign bus.ras_err = err_q;
`else
   logic unused_cfg;
   assign unused_cfg  = ^{bus.ret_en, push, pop, (RAS_DEPTH != 0)};
   assign bus.ras_err = 1'b0;
`endif
endmodule

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr: directed vectors push expected state, a monitor checks it.
module tb_prog_ctr;
`ifdef PROG_CTR_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   typedef struct {
      string       name;
      bit          st, stl, hlt, br, rel, cal, ret;
      logic [11:0] tgt;
      logic [30:0] exp;
   } vec_t;

   typedef struct {
      string       name;
      logic [30:0] exp;
   } exp_t;

   logic clk;
   logic reset;
   logic rst_s;

   prog_ctr_if #(.D(12), .CNT_W(16)) bus ();
   prog_ctr_if #(.D(12), .CNT_W(4))  bus_s ();

   prog_ctr #(.D(12), .START_ADDR(0), .CNT_W(16), .RAS_DEPTH(4)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   prog_ctr #(.D(12), .START_ADDR(0), .CNT_W(4), .RAS_DEPTH(4)) u_sat (
      .clk   (clk),
      .reset (rst_s),
      .bus   (bus_s)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   bit   sat_done = 1'b0;
   exp_t exp_q[$];
   vec_t vecs[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got pc=%0d cnt=%h run=%b done=%b err=%b, required pc=%0d cnt=%h run=%b done=%b err=%b",
                    name, act[30:19], act[18:3], act[2], act[1], act[0],
                    exp[30:19], exp[18:3], exp[2], exp[1], exp[0]);
   endtask

   function automatic logic [30:0] pack(input logic [11:0] pc, input logic [15:0] cnt,
                                        input bit run, input bit dn, input bit err);
      return {pc, cnt, run, dn, err};
   endfunction

   function automatic vec_t mk(input string name, input bit st, input bit stl, input bit hlt,
                               input bit br, input bit rel, input bit cal, input bit ret,
                               input logic [11:0] tgt, input logic [11:0] pc,
                               input logic [15:0] cnt, input bit run, input bit dn, input bit err);
      vec_t v;
      v.name = name; v.st = st; v.stl = stl; v.hlt = hlt; v.br = br; v.rel = rel;
      v.cal = cal; v.ret = ret; v.tgt = tgt; v.exp = pack(pc, cnt, run, dn, err);
      return v;
   endfunction

   task automatic drive_idle();
      bus.start = 0; bus.stall = 0; bus.halt = 0; bus.branch_en = 0;
      bus.rel_en = 0; bus.call_en = 0; bus.ret_en = 0; bus.target = '0;
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      @(negedge clk);
      bus.start = v.st; bus.stall = v.stl; bus.halt = v.hlt; bus.branch_en = v.br;
      bus.rel_en = v.rel; bus.call_en = v.cal; bus.ret_en = v.ret; bus.target = v.tgt;
      e.name = v.name;
      e.exp  = v.exp;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int unsigned waited = 0;
      while (exp_q.size() != 0 && waited < 10) begin
         @(posedge clk);
         #2;
         waited++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected entries pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: every registered update is compared against the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e.name, {bus.prog_ctr, bus.instr_cnt, bus.running, bus.done, bus.ras_err}, e.exp);
         end
      end
   end

   // Narrow-counter instance exercises instr_cnt saturation in a handful of cycles.
   initial begin
      rst_s = 1'b1;
      bus_s.start = 0; bus_s.stall = 0; bus_s.halt = 0; bus_s.branch_en = 0;
      bus_s.rel_en = 0; bus_s.call_en = 0; bus_s.ret_en = 0; bus_s.target = '0;
      repeat (2) @(negedge clk);
      rst_s = 1'b0;
      @(negedge clk);
      bus_s.start = 1'b1;
      @(negedge clk);
      bus_s.start = 1'b0;
      repeat (20) @(negedge clk);
      n_checks++;
      if (bus_s.instr_cnt === 4'hF && bus_s.prog_ctr === 12'd20) n_pass++;
      else $display("FAIL cnt_saturate: got cnt=%h pc=%0d, required cnt=f pc=20",
                    bus_s.instr_cnt, bus_s.prog_ctr);
      sat_done = 1'b1;
   end

   initial begin
      reset = 1'b1;
      drive_idle();
      #1;
      check("reset_state", {bus.prog_ctr, bus.instr_cnt, bus.running, bus.done, bus.ras_err},
            pack(12'd0, 16'd0, 0, 0, 0));
      repeat (2) @(negedge clk);
      reset = 1'b0;

      //                name           st stl hlt br rel cal ret tgt      pc       cnt   run dn err
      vecs.push_back(mk("start",        1, 0,  0, 0, 0,  0,  0, 12'd0,   12'd0,   16'd0,  1, 0, 0));
      vecs.push_back(mk("inc1",         0, 0,  0, 0, 0,  0,  0, 12'd0,   12'd1,   16'd1,  1, 0, 0));
      vecs.push_back(mk("inc2",         0, 0,  0, 0, 0,  0,  0, 12'd0,   12'd2,   16'd2,  1, 0, 0));
      vecs.push_back(mk("inc3",         0, 0,  0, 0, 0,  0,  0, 12'd0,   12'd3,   16'd3,  1, 0, 0));
      vecs.push_back(mk("inc4",         0, 0,  0, 0, 0,  0,  0, 12'd0,   12'd4,   16'd4,  1, 0, 0));
      vecs.push_back(mk("inc5",         0, 0,  0, 0, 0,  0,  0, 12'd0,   12'd5,   16'd5,  1, 0, 0));
      vecs.push_back(mk("stall1",       0, 1,  0, 0, 0,  0,  0, 12'd0,   12'd5,   16'd5,  1, 0, 0));
      vecs.push_back(mk("stall2",       0, 1,  0, 0, 0,  0,  0, 12'd0,   12'd5,   16'd5,  1, 0, 0));
      vecs.push_back(mk("br_abs10",     0, 0,  0, 1, 0,  0,  0, 12'd10,  12'd10,  16'd6,  1, 0, 0));
      vecs.push_back(mk("br_abs503",    0, 0,  0, 1, 0,  0,  0, 12'd503, 12'd503, 16'd7,  1, 0, 0));
      vecs.push_back(mk("br_rel_neg",   0, 0,  0, 1, 1,  0,  0, 12'hFFE, 12'd501, 16'd8,  1, 0, 0));
      vecs.push_back(mk("br_rel_pos",   0, 0,  0, 1, 1,  0,  0, 12'd5,   12'd506, 16'd9,  1, 0, 0));
      vecs.push_back(mk("br_abs4095",   0, 0,  0, 1, 0,  0,  0, 12'hFFF, 12'hFFF, 16'd10, 1, 0, 0));
      vecs.push_back(mk("inc_wrap",     0, 0,  0, 0, 0,  0,  0, 12'd0,   12'd0,   16'd11, 1, 0, 0));
      vecs.push_back(mk("rel_wrap_dn",  0, 0,  0, 1, 1,  0,  0, 12'hFFF, 12'hFFF, 16'd12, 1, 0, 0));
      vecs.push_back(mk("rel_wrap_up",  0, 0,  0, 1, 1,  0,  0, 12'd2,   12'd1,   16'd13, 1, 0, 0));
`ifndef PROG_CTR_RAS_EN
      vecs.push_back(mk("call_as_br",   0, 0,  0, 0, 0,  1,  0, 12'd298, 12'd298, 16'd14, 1, 0, 0));
      vecs.push_back(mk("ret_ignored",  0, 0,  0, 0, 0,  0,  1, 12'd0,   12'd299, 16'd15, 1, 0, 0));
      vecs.push_back(mk("ret_with_br",  0, 0,  0, 1, 0,  0,  1, 12'd100, 12'd100, 16'd16, 1, 0, 0));
`endif
      vecs.push_back(mk("restart",      1, 0,  0, 0, 0,  0,  0, 12'd0,   12'd0,   16'd0,  1, 0, 0));
      vecs.push_back(mk("br_abs20",     0, 0,  0, 1, 0,  0,  0, 12'd20,  12'd20,  16'd1,  1, 0, 0));
      vecs.push_back(mk("halt_stall",   0, 1,  1, 0, 0,  0,  0, 12'd0,   12'd20,  16'd2,  0, 1, 0));
      vecs.push_back(mk("done_br",      0, 0,  0, 1, 0,  0,  0, 12'd77,  12'd20,  16'd2,  0, 1, 0));
      vecs.push_back(mk("done_misc",    0, 1,  1, 0, 0,  1,  1, 12'd9,   12'd20,  16'd2,  0, 1, 0));
      vecs.push_back(mk("done_start",   1, 0,  0, 0, 0,  0,  0, 12'd0,   12'd0,   16'd0,  1, 0, 0));
      vecs.push_back(mk("inc_after",    0, 0,  0, 0, 0,  0,  0, 12'd0,   12'd1,   16'd1,  1, 0, 0));
      vecs.push_back(mk("halt_only",    0, 0,  1, 1, 0,  0,  0, 12'd50,  12'd1,   16'd2,  0, 1, 0));
`ifdef PROG_CTR_RAS_EN
      vecs.push_back(mk("ras_start",    1, 0,  0, 0, 0,  0,  0, 12'd0,   12'd0,   16'd0,  1, 0, 0));
      vecs.push_back(mk("ras_br6",      0, 0,  0, 1, 0,  0,  0, 12'd6,   12'd6,   16'd1,  1, 0, 0));
      vecs.push_back(mk("call298",      0, 0,  0, 0, 0,  1,  0, 12'd298, 12'd298, 16'd2,  1, 0, 0));
      vecs.push_back(mk("ret7",         0, 0,  0, 0, 0,  0,  1, 12'd0,   12'd7,   16'd3,  1, 0, 0));
      vecs.push_back(mk("call_a",       0, 0,  0, 0, 0,  1,  0, 12'd100, 12'd100, 16'd4,  1, 0, 0));
      vecs.push_back(mk("call_b",       0, 0,  0, 0, 0,  1,  0, 12'd200, 12'd200, 16'd5,  1, 0, 0));
      vecs.push_back(mk("call_c",       0, 0,  0, 0, 0,  1,  0, 12'd300, 12'd300, 16'd6,  1, 0, 0));
      vecs.push_back(mk("call_d",       0, 0,  0, 0, 0,  1,  0, 12'd400, 12'd400, 16'd7,  1, 0, 0));
      vecs.push_back(mk("call_ovf",     0, 0,  0, 0, 0,  1,  0, 12'd500, 12'd500, 16'd8,  1, 0, 1));
      vecs.push_back(mk("ret_1",        0, 0,  0, 0, 0,  0,  1, 12'd0,   12'd401, 16'd9,  1, 0, 1));
      vecs.push_back(mk("ret_2",        0, 0,  0, 0, 0,  0,  1, 12'd0,   12'd301, 16'd10, 1, 0, 1));
      vecs.push_back(mk("ret_3",        0, 0,  0, 0, 0,  0,  1, 12'd0,   12'd201, 16'd11, 1, 0, 1));
      vecs.push_back(mk("ret_4",        0, 0,  0, 0, 0,  0,  1, 12'd0,   12'd101, 16'd12, 1, 0, 1));
      vecs.push_back(mk("ret_unf",      0, 0,  0, 0, 0,  0,  1, 12'd0,   12'd102, 16'd13, 1, 0, 1));
`endif
      vecs.push_back(mk("pre_rst_start",1, 0,  0, 0, 0,  0,  0, 12'd0,   12'd0,   16'd0,  1, 0, RAS_ON));
      vecs.push_back(mk("br_abs37",     0, 0,  0, 1, 0,  0,  0, 12'd37,  12'd37,  16'd1,  1, 0, RAS_ON));
      vecs.push_back(mk("stall37",      0, 1,  0, 0, 0,  0,  0, 12'd0,   12'd37,  16'd1,  1, 0, RAS_ON));

      foreach (vecs[i]) run_vec(vecs[i]);
      drain();

      // Reset lands between edges while stalled at 37 and must act without waiting for a clock.
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset", {bus.prog_ctr, bus.instr_cnt, bus.running, bus.done, bus.ras_err},
            pack(12'd0, 16'd0, 0, 0, 0));
      @(negedge clk);
      drive_idle();
      reset = 1'b0;
      run_vec(mk("idle_ignores_br", 0, 0, 0, 1, 0, 0, 0, 12'd55, 12'd0, 16'd0, 0, 0, 0));
      drain();

      begin
         int unsigned waited = 0;
         while (!sat_done && waited < 100) begin
            @(negedge clk);
            waited++;
         end
         if (!sat_done) begin
            n_checks++;
            $display("FAIL sat_wait: got incomplete, required saturation check done");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
